// File: rtl/truth_table_sequencer_if.sv
// Stimulus/response and result bundle between the truth-table sequencer (master)
// and the lab top level / block under test (slave).
interface truth_table_sequencer_if;
    localparam int unsigned VEC_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MASK_W = 8;

    logic              start;
    logic              x_in;
    logic              y_in;
    logic              a;
    logic              b;
    logic              c;
    logic [VEC_W-1:0]  vec_idx;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [MASK_W-1:0] fail_mask;

    modport master (
        input  start, x_in, y_in,
        output a, b, c, vec_idx, busy, done, pass, err_count, fail_mask
    );

    modport slave (
        output start, x_in, y_in,
        input  a, b, c, vec_idx, busy, done, pass, err_count, fail_mask
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all 8 {a,b,c} vectors into the lab block, compares x/y against a golden table.
// Optional macro TTSEQ_FAIL_STOP_EN: the first mismatching vector ends the sweep early.
module truth_table_sequencer #(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    truth_table_sequencer_if.master       bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned VEC_W  = 3;
    localparam int unsigned ERR_W  = 4;
    localparam int unsigned MASK_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(7);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [VEC_W-1:0]  abc_q, abc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [MASK_W-1:0] mask_q, mask_d;

    logic x_exp_c;
    logic y_exp_c;
    logic mismatch_c;
    logic sample_c;
    logic stop_c;

    // Golden truth table of the lab block, evaluated for the vector on the pins
    always_comb begin
        x_exp_c    = ~vec_q[0] ^ (vec_q[2] | vec_q[1]);
        y_exp_c    = vec_q[2] & vec_q[1];
        mismatch_c = (bus.x_in != x_exp_c) || (bus.y_in != y_exp_c);
        sample_c   = (cnt_q >= DWELL_LAST);
    end

`ifdef TTSEQ_FAIL_STOP_EN
    assign stop_c = mismatch_c;
`else
    assign stop_c = 1'b0;
`endif

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                end
            end

            S_RUN: begin
                if (!sample_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (mismatch_c) begin
                        mask_d[vec_q] = 1'b1;
                        err_d         = err_q + ERR_W'(1);
                    end
                    // Early stop keeps vec_idx on the failing vector for inspection
                    if (stop_c) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == '0);
                    end else if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        vec_d   = '0;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
            end
        endcase

        // Pins only carry a vector while sweeping; otherwise park at 000
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        abc_d  = (state_d == S_RUN) ? vec_d : '0;
    end

    assign bus.a         = abc_q[2];
    assign bus.b         = abc_q[1];
    assign bus.c         = abc_q[0];
    assign bus.vec_idx   = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_mask = mask_q;

endmodule
